// File: rtl/pipe_field_engine.sv
// Scrolling pipe field for the Flappy VGA game: LFSR-gapped pipes, pixel coverage, collisions, score.
// Optional FLAPPY_SPEED_RAMP_EN adds score[15:3] to the base scroll speed before the clamp.
module pipe_field_engine #(
  parameter int unsigned NUM_PIPES     = 4,
  parameter int unsigned PIPE_WIDTH    = 50,
  parameter int unsigned GAP_HEIGHT    = 100,
  parameter int unsigned GAP_MIN       = 40,
  parameter int unsigned PIPE_SPACING  = 160,
  parameter int unsigned SCREEN_WIDTH  = 640,
  parameter int unsigned SCREEN_HEIGHT = 480,
  parameter int unsigned BIRD_SIZE     = 30,
  parameter int unsigned SPEED_MAX     = 7,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic [2:0]  speed,
  input  logic [9:0]  x,
  input  logic [8:0]  y,
  input  logic [9:0]  bird_x,
  input  logic [8:0]  bird_y,
  output logic        pipe_pixel,
  output logic [1:0]  game_state,
  output logic [15:0] score,
  output logic        pipe_passed
);

  typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StDead = 2'd2} state_e;

  state_e                       state_q, state_d;
  logic [15:0]                  lfsr_q, lfsr_d;
  logic                         start_q;
  logic [NUM_PIPES-1:0][10:0]   r_q, r_d;
  logic [NUM_PIPES-1:0][8:0]    gap_q, gap_d;
  logic [15:0]                  score_q, score_d;
  logic                         passed_q, passed_d;
  logic                         pix_q, pix_d;
  logic                         start_rise;
  logic [NUM_PIPES-1:0]         hit;
  logic [16:0]                  speed_sum;
  logic [10:0]                  s;
  logic [10:0]                  bird_x_end;
  logic [9:0]                   bird_y_end;
  logic                         in_box, pipe_hit, floor_hit, pass;

  function automatic logic [10:0] init_r(int unsigned i);
    return 11'(SCREEN_WIDTH + PIPE_WIDTH + i * PIPE_SPACING);
  endfunction

  function automatic logic [8:0] init_gap(int unsigned i);
    return 9'(GAP_MIN + 32 * i);
  endfunction

  assign start_rise = start & ~start_q;

`ifdef FLAPPY_SPEED_RAMP_EN
  assign speed_sum = 17'(speed) + 17'(score_q[15:3]);
`else
  assign speed_sum = 17'(speed);
`endif
  assign s = (speed_sum > 17'(SPEED_MAX)) ? 11'(SPEED_MAX) : speed_sum[10:0];

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      hit[i] = ({1'b0, x} < r_q[i]) && (({1'b0, x} + 11'(PIPE_WIDTH)) >= r_q[i]) &&
               (({1'b0, y} < {1'b0, gap_q[i]}) ||
                ({1'b0, y} >= ({1'b0, gap_q[i]} + 10'(GAP_HEIGHT))));
    end
  end

  assign bird_x_end = {1'b0, bird_x} + 11'(BIRD_SIZE);
  assign bird_y_end = {1'b0, bird_y} + 10'(BIRD_SIZE);
  assign in_box     = (x >= bird_x) && ({1'b0, x} <= bird_x_end) &&
                      (y >= bird_y) && ({1'b0, y} <= bird_y_end);
  assign pipe_hit   = (|hit) && in_box;
  assign floor_hit  = frame_tick && (bird_y_end >= 10'(SCREEN_HEIGHT - 1));

  always_comb begin
    state_d  = state_q;
    lfsr_d   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    r_d      = r_q;
    gap_d    = gap_q;
    score_d  = score_q;
    passed_d = 1'b0;
    pix_d    = |hit;
    pass     = 1'b0;
    unique case (state_q)
      StIdle: if (start_rise) state_d = StRun;
      StRun: begin
        // A collision in a tick cycle freezes the pipes and drops that tick's pass.
        if (pipe_hit || floor_hit) begin
          state_d = StDead;
        end else if (frame_tick) begin
          for (int i = 0; i < NUM_PIPES; i++) begin
            if (r_q[i] <= s) begin
              r_d[i]   = r_q[i] - s + 11'(NUM_PIPES * PIPE_SPACING);
              gap_d[i] = 9'(GAP_MIN) + 9'(lfsr_q[7:0]);
            end else begin
              r_d[i] = r_q[i] - s;
            end
            if ((r_q[i] > {1'b0, bird_x}) && (r_d[i] <= {1'b0, bird_x})) pass = 1'b1;
          end
          if (pass && (score_q != 16'hFFFF)) begin
            score_d  = score_q + 16'd1;
            passed_d = 1'b1;
          end
        end
      end
      StDead: begin
        if (start_rise) begin
          state_d = StIdle;
          lfsr_d  = LFSR_SEED;
          score_d = '0;
          pix_d   = 1'b0;
          for (int i = 0; i < NUM_PIPES; i++) begin
            r_d[i]   = init_r(i);
            gap_d[i] = init_gap(i);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      lfsr_q   <= LFSR_SEED;
      start_q  <= 1'b0;
      score_q  <= '0;
      passed_q <= 1'b0;
      pix_q    <= 1'b0;
      for (int i = 0; i < NUM_PIPES; i++) begin
        r_q[i]   <= init_r(i);
        gap_q[i] <= init_gap(i);
      end
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      start_q  <= start;
      score_q  <= score_d;
      passed_q <= passed_d;
      pix_q    <= pix_d;
      r_q      <= r_d;
      gap_q    <= gap_d;
    end
  end

  assign pipe_pixel  = pix_q;
  assign game_state  = state_q;
  assign score       = score_q;
  assign pipe_passed = passed_q;

endmodule

// File: tb/tb_pipe_field_engine.sv
// Bench for pipe_field_engine: coverage vector table, directed game sequences, and random
// stimulus checked every clock against an integer-level behavioural model.
module tb_pipe_field_engine;

  localparam int NP = 4, PW = 50, GH = 100, GMIN = 40, PS = 160;
  localparam int SW = 640, SH = 480, BS = 30, SMAX = 7, SEED = 'hACE1;

  logic        clk = 1'b0;
  logic        reset, frame_tick, start;
  logic [2:0]  speed;
  logic [9:0]  x, bird_x;
  logic [8:0]  y, bird_y;
  logic        pipe_pixel, pipe_passed;
  logic [1:0]  game_state;
  logic [15:0] score;

  always #5 clk = ~clk;

  pipe_field_engine dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .start      (start),
    .speed      (speed),
    .x          (x),
    .y          (y),
    .bird_x     (bird_x),
    .bird_y     (bird_y),
    .pipe_pixel (pipe_pixel),
    .game_state (game_state),
    .score      (score),
    .pipe_passed(pipe_passed)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_state, m_score, m_lfsr;
  int m_r[NP];
  int m_gap[NP];
  bit m_pix, m_passed, m_start_prev;

  typedef struct {
    int x;
    int y;
    bit pix;
  } cov_vec_t;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lfsr_next(int v);
    return (v & 1) ? ((v >> 1) ^ 'hB400) : (v >> 1);
  endfunction

  function automatic void m_init();
    m_state  = 0;
    m_score  = 0;
    m_passed = 0;
    m_pix    = 0;
    m_lfsr   = SEED;
    for (int i = 0; i < NP; i++) begin
      m_r[i]   = SW + PW + i * PS;
      m_gap[i] = GMIN + 32 * i;
    end
  endfunction

  function automatic int eff_speed();
    int s;
`ifdef FLAPPY_SPEED_RAMP_EN
    s = int'(speed) + m_score / 8;
`else
    s = int'(speed);
`endif
    return (s > SMAX) ? SMAX : s;
  endfunction

  // Advances the model by one clock using the inputs currently applied.
  function automatic void model_step();
    int xi, yi, bx, by, s, old, nl;
    bit any_hit, rise, collide, pass;
    xi = int'(x); yi = int'(y); bx = int'(bird_x); by = int'(bird_y);
    any_hit = 0;
    pass    = 0;
    for (int i = 0; i < NP; i++)
      if (xi < m_r[i] && xi + PW >= m_r[i] && (yi < m_gap[i] || yi >= m_gap[i] + GH))
        any_hit = 1;
    rise = start && !m_start_prev;
    nl   = lfsr_next(m_lfsr);
    if (reset) begin
      m_init();
      m_start_prev = 0;
      return;
    end
    m_start_prev = start;
    m_passed     = 0;
    m_pix        = any_hit;
    case (m_state)
      0: if (rise) m_state = 1;
      1: begin
        collide = (any_hit && xi >= bx && xi <= bx + BS && yi >= by && yi <= by + BS) ||
                  (frame_tick && by + BS >= SH - 1);
        if (collide) m_state = 2;
        else if (frame_tick) begin
          s = eff_speed();
          for (int i = 0; i < NP; i++) begin
            old = m_r[i];
            if (old <= s) begin
              m_r[i]   = old - s + NP * PS;
              m_gap[i] = GMIN + (m_lfsr % 256);
            end else begin
              m_r[i] = old - s;
            end
            if (old > bx && m_r[i] <= bx) pass = 1;
          end
          if (pass && m_score < 65535) begin
            m_score++;
            m_passed = 1;
          end
        end
      end
      default: if (rise) begin
        m_init();
        nl = SEED;
      end
    endcase
    m_lfsr = nl;
  endfunction

  task automatic compare();
    chk("game_state", game_state, m_state);
    chk("score", score, m_score);
    chk("pipe_passed", pipe_passed, m_passed);
    chk("pipe_pixel", pipe_pixel, m_pix);
    for (int i = 0; i < NP; i++) begin
      chk($sformatf("r[%0d]", i), dut.r_q[i], m_r[i]);
      chk($sformatf("gap_top[%0d]", i), dut.gap_q[i], m_gap[i]);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic do_frame();
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    repeat (3) cycle();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    frame_tick = 1'b0;
    repeat (2) cycle();
    reset = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    cov_vec_t vecs[13];
    int saved_r[NP];
    int old, n, pulses;

    vecs[0]  = '{0, 0, 0};     vecs[1]  = '{639, 10, 0};  vecs[2]  = '{640, 10, 1};
    vecs[3]  = '{689, 10, 1};  vecs[4]  = '{690, 10, 0};  vecs[5]  = '{650, 39, 1};
    vecs[6]  = '{650, 40, 0};  vecs[7]  = '{650, 139, 0}; vecs[8]  = '{650, 140, 1};
    vecs[9]  = '{800, 71, 1};  vecs[10] = '{800, 72, 0};  vecs[11] = '{849, 172, 1};
    vecs[12] = '{1000, 300, 1};

    m_start_prev = 0;
    m_init();
    speed = 3'd0; x = '0; y = '0; bird_x = 10'd0; bird_y = 9'd200;
    do_reset();

    // Reset values against constants
    chk("rst_state", game_state, 0);
    chk("rst_score", score, 0);
    chk("rst_pipe_pixel", pipe_pixel, 0);
    chk("rst_pipe_passed", pipe_passed, 0);
    chk("rst_r0", dut.r_q[0], 690);  chk("rst_r1", dut.r_q[1], 850);
    chk("rst_r2", dut.r_q[2], 1010); chk("rst_r3", dut.r_q[3], 1170);
    chk("rst_gap0", dut.gap_q[0], 40);  chk("rst_gap1", dut.gap_q[1], 72);
    chk("rst_gap2", dut.gap_q[2], 104); chk("rst_gap3", dut.gap_q[3], 136);

    // Coverage table in IDLE
    for (int k = 0; k < 13; k++) begin
      x = 10'(vecs[k].x);
      y = 9'(vecs[k].y);
      cycle();
      chk($sformatf("cov_vec%0d", k), pipe_pixel, vecs[k].pix);
    end

    // Run at speed 2 for 10 frames
    x = '0; y = '0; speed = 3'd2;
    pulse_start();
    chk("run_state", game_state, 1);
    repeat (10) do_frame();
    chk("run_r0", dut.r_q[0], 670);
    x = 10'd625; y = 9'd10;
    cycle();
    chk("run_pix_body", pipe_pixel, 1);
    y = 9'd100;
    cycle();
    chk("run_pix_gap", pipe_pixel, 0);

    // Wrap and reroll at speed 5
    x = '0; y = '0;
    do_reset();
    speed = 3'd5; bird_x = 10'd300; bird_y = 9'd200;
    pulse_start();
    n = 0;
    while (m_r[0] > 5 && n < 300) begin
      do_frame();
      n++;
    end
    chk("wrap_reached", n < 300, 1);
    old = m_r[0];
    do_frame();
    chk("wrap_r0", dut.r_q[0], old - 5 + NP * PS);
    chk("wrap_gap_range", (dut.gap_q[0] >= 40) && (dut.gap_q[0] <= 295), 1);

    // Score one pass at speed 1
    do_reset();
    speed = 3'd1; bird_x = 10'd100; bird_y = 9'd200;
    pulse_start();
    n = 0;
    while (m_r[0] > 101 && n < 700) begin
      do_frame();
      n++;
    end
    chk("score_reached", n < 700, 1);
    chk("score_before", score, 0);
    pulses = 0;
    frame_tick = 1'b1;
    cycle();
    pulses += int'(pipe_passed);
    chk("score_r0", dut.r_q[0], 100);
    chk("score_after", score, 1);
    frame_tick = 1'b0;
    repeat (4) begin
      cycle();
      pulses += int'(pipe_passed);
    end
    chk("score_pulses", pulses, 1);

    // Collision coinciding with a frame tick: DEAD, pipes frozen
    for (int i = 0; i < NP; i++) saved_r[i] = m_r[i];
    x = 10'd99; y = 9'd0; bird_x = 10'd99; bird_y = 9'd0;
    frame_tick = 1'b1;
    cycle();
    frame_tick = 1'b0;
    chk("dead_state", game_state, 2);
    chk("dead_r0_frozen", dut.r_q[0], 100);
    x = '0;
    repeat (3) do_frame();
    for (int i = 0; i < NP; i++) chk($sformatf("dead_r%0d", i), dut.r_q[i], saved_r[i]);
    chk("dead_score", score, 1);
    start = 1'b1;
    cycle();
    start = 1'b0;
    chk("reinit_state", game_state, 0);
    chk("reinit_score", score, 0);
    chk("reinit_r0", dut.r_q[0], 690);
    chk("reinit_gap3", dut.gap_q[3], 136);
    cycle();

`ifdef FLAPPY_SPEED_RAMP_EN
    // Speed ramp: score 8 adds one pixel per frame
    do_reset();
    x = '0; y = '0; speed = 3'd1; bird_x = 10'd100; bird_y = 9'd200;
    pulse_start();
    n = 0;
    while (m_score < 8 && n < 3000) begin
      do_frame();
      n++;
    end
    chk("ramp_reached", n < 3000, 1);
    for (int i = 0; i < NP; i++) saved_r[i] = m_r[i];
    do_frame();
    for (int i = 0; i < NP; i++)
      if (saved_r[i] > 2) chk($sformatf("ramp_r%0d", i), dut.r_q[i], saved_r[i] - 2);
    speed = 3'd7;
    for (int i = 0; i < NP; i++) saved_r[i] = m_r[i];
    do_frame();
    for (int i = 0; i < NP; i++)
      if (saved_r[i] > 7) chk($sformatf("clamp_r%0d", i), dut.r_q[i], saved_r[i] - 7);
`endif

    // Random play against the model
    do_reset();
    for (int c = 0; c < 6000; c++) begin
      reset      = ($urandom_range(0, 499) == 0);
      frame_tick = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0) start = ~start;
      if ($urandom_range(0, 63) == 0) speed = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) begin
        bird_x = 10'($urandom_range(0, 700));
        bird_y = 9'($urandom_range(0, 460));
      end
      x = 10'($urandom_range(0, 1023));
      y = 9'($urandom_range(0, 511));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_field_engine.md
Name: pipe_field_engine

Overview:
- Parametrised scrolling-obstacle engine for the Flappy VGA game. Replaces the fixed six-column hard-coded pipe logic.
- Maintains NUM_PIPES pipes with LFSR-generated gaps and scrolls them at a programmable speed, once per frame.
- Supplies a registered per-pixel pipe-coverage flag to the colour mux, detects bird/pipe and bird/floor collisions, and keeps score.
- Sits between VGATimingGenerator (x, y, screenEnd) and the output colour mux.

Parameters:
- NUM_PIPES, 4, number of pipes (2..8).
- PIPE_WIDTH, 50, pipe width in pixels.
- GAP_HEIGHT, 100, vertical opening in pixels.
- GAP_MIN, 40, minimum gap top row.
- PIPE_SPACING, 160, distance between adjacent pipe left edges.
- SCREEN_WIDTH, 640, visible width.
- SCREEN_HEIGHT, 480, visible height.
- BIRD_SIZE, 30, bird box edge length minus 1 (box is inclusive).
- SPEED_MAX, 7, clamp for effective scroll speed.
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-clk pulse per frame (screenEnd synchronised by the integrator).
- start  in  1  level button; the block edge-detects it internally.
- speed  in  3  base pixels per frame.
- x  in  10  current pixel column.
- y  in  9  current pixel row.
- bird_x  in  10  bird box left edge.
- bird_y  in  9  bird box top edge.
- pipe_pixel  out  1  current (x,y) lies in a pipe body; registered.
- game_state  out  2  0 = IDLE, 1 = RUN, 2 = DEAD.
- score  out  16  pipes passed, saturating.
- pipe_passed  out  1  one-clk pulse per score increment.

Behaviour:
- Single clock domain. Reset is synchronous, active-high, and has priority over all other inputs.
- Reset / reinit values:
  - game_state = IDLE; score = 0; pipe_passed = 0; pipe_pixel = 0.
  - LFSR = LFSR_SEED.
  - Pipe i right edge r[i] = SCREEN_WIDTH + PIPE_WIDTH + i*PIPE_SPACING, held in 11 bits.
  - gap_top[i] = GAP_MIN + 32*i.
- Requirement: GAP_MIN + 255 + GAP_HEIGHT <= SCREEN_HEIGHT; r[i] must fit in 11 bits.
- LFSR: 16-bit Galois, taps 16,14,13,11. It steps every clk, in all states.
- Effective speed: s = min(speed, SPEED_MAX).
- start_rise = start & ~start_q.
- FSM:
  - IDLE: pipes frozen. start_rise -> RUN.
  - RUN: on frame_tick, for every pipe i:
    - If r[i] <= s: r[i] <= r[i] - s + NUM_PIPES*PIPE_SPACING, and gap_top[i] <= GAP_MIN + LFSR[7:0], sampled in that same cycle (wrap and reroll).
    - Otherwise: r[i] <= r[i] - s.
    - s = 0 freezes the pipes.
  - DEAD: pipes and score frozen. start_rise -> reinit all state to the reset values and go to IDLE. A second start_rise is needed to run again.
- Scoring: in RUN, on frame_tick, if r[i] > bird_x before the update and r[i] <= bird_x after the update, then score <= score + 1 (saturates at 16'hFFFF) and pipe_passed = 1 on the next clk.
  - Integration constraint: PIPE_SPACING > PIPE_WIDTH + SPEED_MAX, so at most one pass per tick.
- Coverage: hit_i = (x < r[i]) && (x + PIPE_WIDTH >= r[i]) && (y < gap_top[i] || y >= gap_top[i] + GAP_HEIGHT).
  - pipe_pixel <= OR of all hit_i, 1-clk latency, in every state.
  - x, y are held for 4 clk per pixel, so the latency is invisible at the 25 MHz pixel rate.
- Collision, evaluated in RUN only:
  - Bird/pipe: if any hit_i is true while x is in [bird_x, bird_x+BIRD_SIZE] and y is in [bird_y, bird_y+BIRD_SIZE], then game_state <= DEAD on the next clk.
  - Floor: on frame_tick, if bird_y + BIRD_SIZE >= SCREEN_HEIGHT - 1, then DEAD.
- Simultaneous events:
  - frame_tick and collision in the same clk: DEAD wins and pipes do not move that tick. A score pass in that tick is not counted.
  - reset overrides everything.
  - start_rise while in RUN: ignored.

Optional Feature:
- Macro: FLAPPY_SPEED_RAMP_EN.
- Defined: s = min(speed + score[15:3], SPEED_MAX). Speed rises by 1 every 8 points; the sum is computed at 17 bits before the clamp.
- Undefined: s = min(speed, SPEED_MAX); score does not affect speed.

Test Plan:
- Reset with defaults -> game_state=0, score=0, r = {690, 850, 1010, 1170}, gap_top = {40, 72, 104, 136}, pipe_pixel=0 at (0,0).
- start pulse, speed=2, 10 frame_ticks, bird at (0,200) -> r[0]=670. pipe_pixel=1 at (625,10) and 0 at (625,100) one clk after presentation.
- speed=5, bird_y=200, run until r[0] <= 5 -> on that tick r[0] wraps to old r[0] - 5 + 640, and gap_top[0] equals 40 + LFSR[7:0] in the range [40, 295].
- bird_x=100, speed=1, bird clear of gaps -> score goes 0->1 with a single pipe_passed pulse on the tick where r[0] goes from 101 to 100.
- Bird box overlaps a pipe body during pixel scan -> game_state=2 one clk later; further frame_ticks leave r[] and score unchanged. start -> game_state=0 with reset values restored.
- With FLAPPY_SPEED_RAMP_EN, speed=1, score forced to 8 via passes -> r decreases by 2 per tick. At speed=7 the clamp holds s at 7.
